// File: rtl/uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_frame
// Purpose  : Parametrised UART transmitter. It has an internal baud divider,
//            optional even/odd parity, and 1 or 2 stop bits. Words are taken
//            in through a valid/ready handshake and latched when accepted.
// Ports    : tx_clk   - transmit clock, rising-edge active
//            rst_n    - asynchronous active-low reset
//            tx_data  - word to send, sampled only on accept
//            tx_valid - source presents a word on tx_data
//            tx_ready - block can accept a word (IDLE only)
//            tx_out   - registered serial line, idle-high
//            tx_busy  - frame in progress (any state except IDLE)
//            tx_done  - one-cycle pulse on the edge that leaves STOP
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_frame #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  tx_clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx_out,
  output logic                  tx_busy,
  output logic                  tx_done
);

  // A divider of 1 still needs a 1-bit counter. That counter then sits at 0
  // for good, so every cycle ends a bit.
  localparam int c_BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int c_BIT_W  = $clog2(DATA_WIDTH + 1);

  localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [c_BIT_W-1:0]  c_DATA_LAST = c_BIT_W'(DATA_WIDTH - 1);
  localparam logic [c_BIT_W-1:0]  c_STOP_LAST = c_BIT_W'((STOP_BITS == 2) ? 1 : 0);

  // PARITY_MODE 3 (and any other value) falls back to no parity.
  localparam logic c_PAR_EN  = (PARITY_MODE == 1) || (PARITY_MODE == 2);
  localparam logic c_PAR_ODD = (PARITY_MODE == 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [c_BAUD_W-1:0]   r_baud_cnt;
  logic [c_BAUD_W-1:0]   w_baud_nxt;
  logic [c_BIT_W-1:0]    r_bit_cnt;
  logic [c_BIT_W-1:0]    w_bit_nxt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] w_shift_nxt;
  logic                  r_parity;
  logic                  w_parity_nxt;
  logic                  r_tx_out;
  logic                  w_tx_out_nxt;
  logic                  r_done;
  logic                  w_done_nxt;
  logic                  w_bit_end;

  assign w_bit_end = (r_baud_cnt == c_BAUD_LAST);

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_parity   <= 1'b0;
      r_tx_out   <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_baud_cnt <= w_baud_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_shift    <= w_shift_nxt;
      r_parity   <= w_parity_nxt;
      r_tx_out   <= w_tx_out_nxt;
      r_done     <= w_done_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and next-output logic. tx_out is computed one bit ahead, so
  // the registered line changes on the same edge as the state.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_baud_nxt   = r_baud_cnt;
    w_bit_nxt    = r_bit_cnt;
    w_shift_nxt  = r_shift;
    w_parity_nxt = r_parity;
    w_tx_out_nxt = r_tx_out;
    w_done_nxt   = 1'b0;

    if (r_state != S_IDLE) begin
      w_baud_nxt = w_bit_end ? '0 : r_baud_cnt + 1'b1;
    end

    case (r_state)
      S_IDLE: begin
        w_tx_out_nxt = 1'b1;
        w_baud_nxt   = '0;
        w_bit_nxt    = '0;
        if (tx_valid) begin
          w_shift_nxt  = tx_data;
          w_parity_nxt = (^tx_data) ^ c_PAR_ODD;
          w_state_nxt  = S_START;
          w_tx_out_nxt = 1'b0;
        end
      end

      S_START: begin
        if (w_bit_end) begin
          w_state_nxt  = S_DATA;
          w_bit_nxt    = '0;
          w_tx_out_nxt = r_shift[0];
        end
      end

      S_DATA: begin
        if (w_bit_end) begin
          if (r_bit_cnt == c_DATA_LAST) begin
            w_bit_nxt = '0;
            if (c_PAR_EN) begin
              w_state_nxt  = S_PARITY;
              w_tx_out_nxt = r_parity;
            end else begin
              w_state_nxt  = S_STOP;
              w_tx_out_nxt = 1'b1;
            end
          end else begin
            // Bit 0 is always the one on the line, so the next bit is
            // shift[1]. DATA_WIDTH is at least 5, so that index is in range.
            w_bit_nxt    = r_bit_cnt + 1'b1;
            w_tx_out_nxt = r_shift[1];
            w_shift_nxt  = r_shift >> 1;
          end
        end
      end

      S_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt  = S_STOP;
          w_bit_nxt    = '0;
          w_tx_out_nxt = 1'b1;
        end
      end

      S_STOP: begin
        w_tx_out_nxt = 1'b1;
        if (w_bit_end) begin
          if (r_bit_cnt == c_STOP_LAST) begin
            w_state_nxt = S_IDLE;
            w_bit_nxt   = '0;
            w_done_nxt  = 1'b1;
          end else begin
            w_bit_nxt = r_bit_cnt + 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt  = S_IDLE;
        w_baud_nxt   = '0;
        w_bit_nxt    = '0;
        w_tx_out_nxt = 1'b1;
      end
    endcase
  end

  assign tx_out   = r_tx_out;
  assign tx_done  = r_done;
  assign tx_ready = (r_state == S_IDLE);
  assign tx_busy  = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_frame
// Purpose  : Self-checking bench for uart_tx_frame. Five instances cover the
//            configurations: 8N1, 8E1, 8O1, 8N2 (all at 4 clocks per bit), and
//            5O1 at 1 clock per bit. The expected line level for each cycle
//            is queued when a word is driven, then popped against tx_out.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_frame;

  logic            tx_clk = 1'b0;
  logic            rst_n  = 1'b0;
  logic [4:0]      valid  = '0;
  logic [4:0][7:0] data   = '0;
  logic [4:0]      out;
  logic [4:0]      ready;
  logic [4:0]      busy;
  logic [4:0]      done;

  int checks = 0;
  int errors = 0;
  logic exp_q[$];

  always #5 tx_clk = ~tx_clk;

  uart_tx_frame #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_MODE(0), .STOP_BITS(1)) u0 (
    .tx_clk(tx_clk), .rst_n(rst_n), .tx_data(data[0]), .tx_valid(valid[0]),
    .tx_ready(ready[0]), .tx_out(out[0]), .tx_busy(busy[0]), .tx_done(done[0]));
  uart_tx_frame #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_MODE(1), .STOP_BITS(1)) u1 (
    .tx_clk(tx_clk), .rst_n(rst_n), .tx_data(data[1]), .tx_valid(valid[1]),
    .tx_ready(ready[1]), .tx_out(out[1]), .tx_busy(busy[1]), .tx_done(done[1]));
  uart_tx_frame #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_MODE(2), .STOP_BITS(1)) u2 (
    .tx_clk(tx_clk), .rst_n(rst_n), .tx_data(data[2]), .tx_valid(valid[2]),
    .tx_ready(ready[2]), .tx_out(out[2]), .tx_busy(busy[2]), .tx_done(done[2]));
  uart_tx_frame #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_MODE(0), .STOP_BITS(2)) u3 (
    .tx_clk(tx_clk), .rst_n(rst_n), .tx_data(data[3]), .tx_valid(valid[3]),
    .tx_ready(ready[3]), .tx_out(out[3]), .tx_busy(busy[3]), .tx_done(done[3]));
  uart_tx_frame #(.DATA_WIDTH(5), .CLKS_PER_BIT(1), .PARITY_MODE(2), .STOP_BITS(1)) u4 (
    .tx_clk(tx_clk), .rst_n(rst_n), .tx_data(data[4][4:0]), .tx_valid(valid[4]),
    .tx_ready(ready[4]), .tx_out(out[4]), .tx_busy(busy[4]), .tx_done(done[4]));

  function automatic int cfg_dw(int i);
    return (i == 4) ? 5 : 8;
  endfunction
  function automatic int cfg_cpb(int i);
    return (i == 4) ? 1 : 4;
  endfunction
  function automatic int cfg_pm(int i);
    return (i == 1) ? 1 : ((i == 2 || i == 4) ? 2 : 0);
  endfunction
  function automatic int cfg_sb(int i);
    return (i == 3) ? 2 : 1;
  endfunction

  // Queue the expected line level for every cycle of one frame.
  task automatic push_frame(input int idx, input logic [7:0] word, output int f);
    int   start;
    logic p;
    start = exp_q.size();
    p = 1'b0;
    for (int c = 0; c < cfg_cpb(idx); c++) exp_q.push_back(1'b0);
    for (int b = 0; b < cfg_dw(idx); b++) begin
      p = p ^ word[b];
      for (int c = 0; c < cfg_cpb(idx); c++) exp_q.push_back(word[b]);
    end
    if (cfg_pm(idx) == 1 || cfg_pm(idx) == 2) begin
      for (int c = 0; c < cfg_cpb(idx); c++) exp_q.push_back((cfg_pm(idx) == 2) ? ~p : p);
    end
    for (int c = 0; c < cfg_sb(idx) * cfg_cpb(idx); c++) exp_q.push_back(1'b1);
    f = exp_q.size() - start;
  endtask

  // Present one word for a single cycle. Return at #1 after the accept edge,
  // with tx_data scrambled so that any late sampling would show up.
  task automatic start_frame(input int idx, input logic [7:0] word, output int f);
    push_frame(idx, word, f);
    @(negedge tx_clk);
    valid[idx] = 1'b1;
    data[idx]  = word;
    @(posedge tx_clk);
    #1;
    valid[idx] = 1'b0;
    data[idx]  = ~word;
  endtask

  // Start at #1 after the accept edge (cycle 0 of the frame). Compare f cycles
  // against the queue, then check the tx_done cycle.
  task automatic check_frame(input int idx, input int f, input string name);
    logic e;
    for (int k = 0; k < f; k++) begin
      if (k > 0) begin
        @(posedge tx_clk);
        #1;
      end
      e = exp_q.pop_front();
      checks++;
      if (out[idx] !== e || busy[idx] !== 1'b1 || done[idx] !== 1'b0 || ready[idx] !== 1'b0) begin
        errors++;
        $display("FAIL %s cycle %0d: out/busy/done/ready = %b%b%b%b, required %b100",
                 name, k, out[idx], busy[idx], done[idx], ready[idx], e);
      end
    end
    @(posedge tx_clk);
    #1;
    checks++;
    if (done[idx] !== 1'b1 || busy[idx] !== 1'b0 || ready[idx] !== 1'b1 || out[idx] !== 1'b1) begin
      errors++;
      $display("FAIL %s end-of-frame: done/busy/ready/out = %b%b%b%b, required 1011",
               name, done[idx], busy[idx], ready[idx], out[idx]);
    end
  endtask

  task automatic check_idle_after(input int idx, input string name);
    @(posedge tx_clk);
    #1;
    checks++;
    if (done[idx] !== 1'b0 || busy[idx] !== 1'b0 || out[idx] !== 1'b1) begin
      errors++;
      $display("FAIL %s post-done: done/busy/out = %b%b%b, required 001",
               name, done[idx], busy[idx], out[idx]);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge tx_clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out[i] !== 1'b1 || ready[i] !== 1'b1 || busy[i] !== 1'b0 || done[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset inst %0d: out/ready/busy/done = %b%b%b%b, required 1100",
                 i, out[i], ready[i], busy[i], done[i]);
      end
    end
    @(negedge tx_clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int f;
    start_frame(0, 8'hA5, f);
    check_frame(0, f, "basic_A5");
    check_idle_after(0, "basic_A5");
  endtask

  task automatic test_parity();
    int f;
    start_frame(1, 8'h07, f);
    check_frame(1, f, "even_07");
    check_idle_after(1, "even_07");
    start_frame(2, 8'h07, f);
    check_frame(2, f, "odd_07");
    check_idle_after(2, "odd_07");
    start_frame(1, 8'h03, f);
    check_frame(1, f, "even_03");
    check_idle_after(1, "even_03");
  endtask

  task automatic test_stop_bits();
    int f;
    start_frame(3, 8'h81, f);
    check_frame(3, f, "stop2_81");
    check_idle_after(3, "stop2_81");
  endtask

  task automatic test_back_to_back();
    int f1;
    int f2;
    push_frame(0, 8'h55, f1);
    push_frame(0, 8'hAA, f2);
    @(negedge tx_clk);
    valid[0] = 1'b1;
    data[0]  = 8'h55;
    @(posedge tx_clk);
    #1;
    data[0] = 8'hAA;
    check_frame(0, f1, "b2b_55");
    // tx_valid is still high in the done cycle, so the next edge accepts.
    @(posedge tx_clk);
    #1;
    valid[0] = 1'b0;
    data[0]  = 8'h00;
    check_frame(0, f2, "b2b_AA");
    check_idle_after(0, "b2b_AA");
  endtask

  task automatic test_ignore_busy();
    int   f;
    logic seen;
    start_frame(0, 8'h5A, f);
    fork
      check_frame(0, f, "ignore_5A");
      begin
        repeat (10) @(negedge tx_clk);
        valid[0] = 1'b1;
        data[0]  = 8'hFF;
        @(negedge tx_clk);
        valid[0] = 1'b0;
      end
    join
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(posedge tx_clk);
      #1;
      if (busy[0] !== 1'b0 || out[0] !== 1'b1 || done[0] !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL ignore_extra_frame: activity seen = %b, required 0", seen);
    end
  endtask

  task automatic test_reset_mid();
    int         f;
    logic       dseen;
    logic [7:0] w;
    w = 8'hC3;
    @(negedge tx_clk);
    valid[0] = 1'b1;
    data[0]  = w;
    @(posedge tx_clk);
    #1;
    valid[0] = 1'b0;
    // Bit 3 occupies frame cycles 16..19.
    repeat (17) @(posedge tx_clk);
    #1;
    checks++;
    if (out[0] !== w[3]) begin
      errors++;
      $display("FAIL rstmid_bit3: out = %b, required %b", out[0], w[3]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out[0] !== 1'b1 || ready[0] !== 1'b1 || busy[0] !== 1'b0 || done[0] !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async: out/ready/busy/done = %b%b%b%b, required 1100",
               out[0], ready[0], busy[0], done[0]);
    end
    dseen = 1'b0;
    repeat (3) begin
      @(posedge tx_clk);
      #1;
      dseen = dseen | done[0];
    end
    @(negedge tx_clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(posedge tx_clk);
      #1;
      dseen = dseen | done[0] | busy[0];
    end
    checks++;
    if (dseen !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_no_resume: done/busy seen = %b, required 0", dseen);
    end
    start_frame(0, 8'h3C, f);
    check_frame(0, f, "rstmid_3C");
    check_idle_after(0, "rstmid_3C");
  endtask

  task automatic test_corner();
    int f;
    start_frame(4, 8'h1F, f);
    check_frame(4, f, "corner_1F");
    check_idle_after(4, "corner_1F");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_stop_bits();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid();
    test_corner();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- Parametrised UART transmitter, the successor to the fixed 8N1 serializer.
- Adds four things over the fixed serializer:
  - an internal baud divider, so one bit lasts CLKS_PER_BIT tx_clk cycles;
  - optional even/odd parity;
  - 1 or 2 stop bits;
  - a valid/ready input handshake with input data capture.
- Sits between a byte source (FIFO or register interface) and the serial pin.

Parameters:
- DATA_WIDTH, 8, data bits per frame; legal range 5..9.
- CLKS_PER_BIT, 16, tx_clk cycles per serial bit; must be >= 1.
- PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd; value 3 is treated as none.
- STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
- tx_clk, input, 1, transmit clock; all state updates on its rising edge.
- rst_n, input, 1, reset; asynchronous, active-low.
- tx_data, input, DATA_WIDTH, word to send; sampled only at handshake.
- tx_valid, input, 1, source has a word on tx_data.
- tx_ready, output, 1, block can accept a word; high only in IDLE.
- tx_out, output, 1, serial line, idle-high, registered.
- tx_busy, output, 1, high while a frame is in progress (any state except IDLE).
- tx_done, output, 1, one-cycle pulse marking the end of a frame.

Behaviour:
- Reset (asynchronous, rst_n low), applies immediately including mid-frame, with no partial frame resumed afterwards:
  - state = IDLE, tx_out = 1, tx_ready = 1, tx_busy = 0, tx_done = 0;
  - baud counter, bit counter and shift register cleared.
- States: IDLE, START, DATA, PARITY, STOP. Encoding is free; no unreachable states may lock up, and the default branch goes to IDLE.
- Handshake:
  - accept occurs on a rising edge where tx_valid && tx_ready.
  - On that edge: tx_data is latched into the shift register, parity is computed from the latched word, state -> START, tx_out -> 0, tx_ready -> 0, tx_busy -> 1.
  - tx_valid while busy is ignored; the word is not queued.
  - tx_data changes after accept have no effect on the frame in progress.
- Baud counter:
  - counts 0..CLKS_PER_BIT-1 within each bit;
  - the bit ends on the edge where the count equals CLKS_PER_BIT-1; the counter then wraps to 0.
  - With CLKS_PER_BIT = 1, every bit lasts exactly one cycle.
- START: tx_out = 0 for one bit time -> DATA.
- DATA:
  - tx_out = data bit[i], LSB first, i = 0..DATA_WIDTH-1;
  - the bit counter advances at each bit end.
  - After bit DATA_WIDTH-1: -> PARITY if PARITY_MODE is 1 or 2, else -> STOP.
- PARITY: one bit time. Even mode sends XOR of the data bits; odd mode sends its inverse.
- STOP: tx_out = 1 for STOP_BITS bit times -> IDLE.
- Frame length: F = (1 + DATA_WIDTH + P + STOP_BITS) * CLKS_PER_BIT cycles, where P = 1 if parity is enabled, else 0. It is measured from the first cycle tx_out = 0 to the last stop cycle inclusive.
- End of frame: on the edge that leaves STOP, state -> IDLE, tx_done = 1 for exactly one cycle, tx_ready = 1, tx_busy = 0.
- Back-to-back frames: if tx_valid is high during the tx_done cycle, the next word is accepted on the following edge. The minimum inter-frame idle-high gap is one tx_clk cycle beyond the stop bits.
- Width rules:
  - baud counter width is $clog2(CLKS_PER_BIT), minimum 1;
  - bit counter width is $clog2(DATA_WIDTH+1);
  - no out-of-range index into the shift register in any state.
- tx_out is driven from a flop only; no combinational path from tx_data or tx_valid to tx_out.

Test Plan:
- Basic frame. Config: DATA_WIDTH=8, CLKS_PER_BIT=4, no parity, 1 stop. Send 8'hA5.
  - Required tx_out, per 4-cycle bit: 0 | 1,0,1,0,0,1,0,1 | 1.
  - Frame is 40 cycles; tx_done pulses once in cycle 41; tx_busy is high for exactly 40 cycles.
- Parity. Send 8'h07 (three ones).
  - Even: parity bit = 1. Odd: parity bit = 0.
  - Send 8'h03 in even mode: parity bit = 0. Frame is 44 cycles.
- Stop bits. STOP_BITS=2, CLKS_PER_BIT=4: stop region is 8 cycles high; frame is 44 cycles without parity.
- Handshake.
  - Hold tx_valid high with 8'h55 then 8'hAA back-to-back: two complete frames, exactly one idle-high cycle between them.
  - Pulse tx_valid mid-frame with 8'hFF: ignored; the frame in progress is unchanged and no extra frame is sent.
- Reset mid-operation. Assert rst_n low during data bit 3: tx_out = 1 immediately (before the next clock edge), tx_ready = 1, tx_done never pulses. After release, a new 8'h3C frame is correct.
- Corner config. CLKS_PER_BIT=1, DATA_WIDTH=5, odd parity. Send 5'h1F: tx_out = 0,1,1,1,1,1,0,1, one bit per cycle (odd parity bit = 0).
